// File: rtl/dsp_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_if
// Purpose  : Register bus, memory read port and result signals of the
//            multiply-accumulate engine, bundled for port connection.
// Revision : 1.0  initial release
// ============================================================================
interface dsp_mac_if #(
    parameter int BUS_WIDTH  = 24,
    parameter int ADDR_WIDTH = 6
);
    logic                  en;
    logic                  start;
    logic [2:0]            addr;
    logic [BUS_WIDTH-1:0]  din;
    logic                  we;
    logic [BUS_WIDTH-1:0]  memdout;
    logic [ADDR_WIDTH-1:0] memaddr;
    logic [BUS_WIDTH-1:0]  dout;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    // Config bus plus memory side: drives requests and read data
    modport master (
        output en, start, addr, din, we, memdout,
        input  memaddr, dout, busy, done, ovf
    );

    // Engine side
    modport slave (
        input  en, start, addr, din, we, memdout,
        output memaddr, dout, busy, done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_engine
// Purpose  : Register-programmed multiply-accumulate engine. Streams LEN words
//            from a synchronous memory starting at BASE, multiplies each by
//            COEF, accumulates, then shifts and saturates/wraps the result.
// Revision : 1.0  initial release
// ============================================================================
module dsp_mac_engine #(
    parameter int   BUS_WIDTH  = 24,
    parameter int   ADDR_WIDTH = 6,
    parameter logic RST_VAL    = 1'b0,
    parameter int   ACC_GUARD  = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dsp_mac_if.slave   bus
);

    localparam int PROD_W = BUS_WIDTH + 8;
    localparam int ACC_W  = BUS_WIDTH + 8 + ADDR_WIDTH + ACC_GUARD;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    state_t                r_state;

    // Programmable registers
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_len;
    logic [7:0]            r_coef;
    logic [1:0]            r_mode;
    logic [3:0]            r_shift;

    // Snapshot taken at start so a same-cycle write cannot affect the run
    logic [CNT_W-1:0]      r_run_len;
    logic [7:0]            r_run_coef;
    logic [1:0]            r_run_mode;
    logic [3:0]            r_run_shift;

    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [ADDR_WIDTH-1:0] r_memaddr;
    logic [BUS_WIDTH-1:0]  r_dout;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;

    logic signed [PROD_W-1:0] w_prod_s;
    logic [PROD_W-1:0]        w_prod_u;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_shifted;
    logic [ACC_W-BUS_WIDTH:0] w_hi_s;
    logic [ACC_W-BUS_WIDTH-1:0] w_hi_u;
    logic                     w_oor;
    logic [BUS_WIDTH-1:0]     w_sat;
    logic [BUS_WIDTH-1:0]     w_result;
    logic                     w_unused_din;

    // Only the low register-field bits of din are ever stored
    assign w_unused_din = ^bus.din[BUS_WIDTH-1:8];

    // Product of the current memory word and coefficient, extended to the accumulator width
    always_comb begin
        w_prod_s = $signed({{8{bus.memdout[BUS_WIDTH-1]}}, bus.memdout})
                 * $signed({{BUS_WIDTH{r_run_coef[7]}}, r_run_coef});
        w_prod_u = {8'd0, bus.memdout} * {{BUS_WIDTH{1'b0}}, r_run_coef};
        if (r_run_mode[1]) begin
            w_prod_ext = {{(ACC_W-PROD_W){w_prod_s[PROD_W-1]}}, w_prod_s};
        end else begin
            w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, w_prod_u};
        end
    end

    // Final scaling, range check and saturate/wrap selection
    always_comb begin
        if (r_run_mode[1]) begin
            w_shifted = $unsigned($signed(r_acc) >>> r_run_shift);
        end else begin
            w_shifted = r_acc >> r_run_shift;
        end
        w_hi_s = w_shifted[ACC_W-1:BUS_WIDTH-1];
        w_hi_u = w_shifted[ACC_W-1:BUS_WIDTH];
        if (r_run_mode[1]) begin
            // Signed result fits when all bits above the sign bit match it
            w_oor = !((&w_hi_s) || !(|w_hi_s));
            w_sat = w_shifted[ACC_W-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                       : {1'b0, {(BUS_WIDTH-1){1'b1}}};
        end else begin
            w_oor = |w_hi_u;
            w_sat = {BUS_WIDTH{1'b1}};
        end
        if (r_run_mode[0] && w_oor) begin
            w_result = w_sat;
        end else begin
            w_result = w_shifted[BUS_WIDTH-1:0];
        end
    end

    // Register file, run sequencer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_coef      <= 8'd1;
            r_mode      <= 2'd0;
            r_shift     <= 4'd0;
            r_run_len   <= '0;
            r_run_coef  <= 8'd1;
            r_run_mode  <= 2'd0;
            r_run_shift <= 4'd0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_memaddr   <= '0;
            r_dout      <= {BUS_WIDTH{RST_VAL}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (bus.en) begin
            r_done <= 1'b0;
            if (bus.we && !r_busy) begin
                case (bus.addr)
                    3'd0:    r_base  <= bus.din[ADDR_WIDTH-1:0];
                    3'd1:    r_len   <= bus.din[CNT_W-1:0];
                    3'd2:    r_coef  <= bus.din[7:0];
                    3'd3:    r_mode  <= bus.din[1:0];
                    3'd4:    r_shift <= bus.din[3:0];
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ovf       <= 1'b0;
                        r_acc       <= '0;
                        r_busy      <= 1'b1;
                        r_memaddr   <= r_base;
                        r_cnt       <= CNT_W'(1);
                        r_run_len   <= r_len;
                        r_run_coef  <= r_coef;
                        r_run_mode  <= r_mode;
                        r_run_shift <= r_shift;
                        if (r_len == '0) begin
                            r_state <= S_FINAL;
                        end else if (r_len == CNT_W'(1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Word addressed last cycle is on memdout now
                    r_acc     <= r_acc + w_prod_ext;
                    r_memaddr <= r_memaddr + ADDR_WIDTH'(1);
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == r_run_len - CNT_W'(1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_dout  <= w_result;
                    r_ovf   <= w_oor;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.memaddr = r_memaddr;
    assign bus.dout    = r_dout;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_engine
// Purpose  : Directed self-checking bench for dsp_mac_engine (24-bit and
//            16-bit instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_engine;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dsp_mac_if #(.BUS_WIDTH(24), .ADDR_WIDTH(6)) bus24 ();
    dsp_mac_if #(.BUS_WIDTH(16), .ADDR_WIDTH(6)) bus16 ();

    logic [23:0] mem24 [0:63];
    logic [15:0] mem16 [0:63];

    // Synchronous memory models: data follows the registered address
    assign bus24.memdout = mem24[bus24.memaddr];
    assign bus16.memdout = mem16[bus16.memaddr];

    dsp_mac_engine #(
        .BUS_WIDTH(24), .ADDR_WIDTH(6), .RST_VAL(1'b1), .ACC_GUARD(4)
    ) u_dut24 (
        .clk(clk), .rst(rst), .bus(bus24)
    );

    dsp_mac_engine #(
        .BUS_WIDTH(16), .ADDR_WIDTH(6), .RST_VAL(1'b0), .ACC_GUARD(4)
    ) u_dut16 (
        .clk(clk), .rst(rst), .bus(bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr24(input logic [2:0] a, input logic [23:0] d);
        bus24.addr = a;
        bus24.din  = d;
        bus24.we   = 1'b1;
        tick();
        bus24.we   = 1'b0;
    endtask

    task automatic wr16(input logic [2:0] a, input logic [15:0] d);
        bus16.addr = a;
        bus16.din  = d;
        bus16.we   = 1'b1;
        tick();
        bus16.we   = 1'b0;
    endtask

    task automatic go24();
        bus24.start = 1'b1;
        tick();
        bus24.start = 1'b0;
    endtask

    task automatic go16();
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) begin
            mem24[i] = 24'(i + 1);
            mem16[i] = 16'h7FFF;
        end
        rst = 1'b1;
        bus24.en = 1'b1; bus24.start = 1'b0; bus24.we = 1'b0; bus24.addr = 3'd0; bus24.din = '0;
        bus16.en = 1'b1; bus16.start = 1'b0; bus16.we = 1'b0; bus16.addr = 3'd0; bus16.din = '0;
        tick();
        tick();

        // Reset state
        chk("rst_dout24",  bus24.dout, 24'hFFFFFF);
        chk("rst_maddr24", bus24.memaddr, 6'd0);
        chk("rst_busy24",  bus24.busy, 1'b0);
        chk("rst_done24",  bus24.done, 1'b0);
        chk("rst_ovf24",   bus24.ovf, 1'b0);
        chk("rst_dout16",  bus16.dout, 16'h0000);
        rst = 1'b0;
        tick();

        // Basic unsigned wrap run: (3+4+5)*2 = 24
        wr24(3'd0, 24'd2);
        wr24(3'd1, 24'd3);
        wr24(3'd2, 24'd2);
        wr24(3'd3, 24'd0);
        go24();
        chk("t1_busy_e0",  bus24.busy, 1'b1);
        chk("t1_maddr_e0", bus24.memaddr, 6'd2);
        tick();
        chk("t1_maddr_e1", bus24.memaddr, 6'd3);
        tick();
        chk("t1_maddr_e2", bus24.memaddr, 6'd4);
        chk("t1_done_e2",  bus24.done, 1'b0);
        tick();
        chk("t1_done_e3",  bus24.done, 1'b0);
        tick();
        chk("t1_done_e4",  bus24.done, 1'b1);
        chk("t1_dout",     bus24.dout, 24'd24);
        chk("t1_ovf",      bus24.ovf, 1'b0);
        chk("t1_busy_e4",  bus24.busy, 1'b0);
        tick();
        chk("t1_done_e5",  bus24.done, 1'b0);

        // Address wrap: 62,63,0,1 -> 63+64+1+2 = 130
        wr24(3'd0, 24'd62);
        wr24(3'd1, 24'd4);
        wr24(3'd2, 24'd1);
        go24();
        chk("t2_maddr_e0", bus24.memaddr, 6'd62);
        tick();
        chk("t2_maddr_e1", bus24.memaddr, 6'd63);
        tick();
        chk("t2_maddr_e2", bus24.memaddr, 6'd0);
        tick();
        chk("t2_maddr_e3", bus24.memaddr, 6'd1);
        tick();
        chk("t2_done_e4",  bus24.done, 1'b0);
        tick();
        chk("t2_done_e5",  bus24.done, 1'b1);
        chk("t2_dout",     bus24.dout, 24'd130);

        // Signed: (-1*3)*2 >>> 1 = -3
        mem24[10] = 24'hFFFFFF;
        mem24[11] = 24'hFFFFFF;
        wr24(3'd0, 24'd10);
        wr24(3'd1, 24'd2);
        wr24(3'd2, 24'd3);
        wr24(3'd3, 24'd2);
        wr24(3'd4, 24'd1);
        go24();
        tick();
        tick();
        chk("t3_done_e2", bus24.done, 1'b0);
        tick();
        chk("t3_done_e3", bus24.done, 1'b1);
        chk("t3_dout",    bus24.dout, 24'hFFFFFD);
        chk("t3_ovf",     bus24.ovf, 1'b0);

        // LEN=0: done one cycle after start, dout=0
        wr24(3'd1, 24'd0);
        go24();
        chk("t4_busy_e0", bus24.busy, 1'b1);
        tick();
        chk("t4_done_e1", bus24.done, 1'b1);
        chk("t4_dout",    bus24.dout, 24'd0);

        // Same-cycle start+write: run uses old COEF=2, write lands
        wr24(3'd0, 24'd0);
        wr24(3'd1, 24'd1);
        wr24(3'd2, 24'd2);
        wr24(3'd3, 24'd0);
        wr24(3'd4, 24'd0);
        bus24.start = 1'b1;
        bus24.we    = 1'b1;
        bus24.addr  = 3'd2;
        bus24.din   = 24'd5;
        tick();
        bus24.start = 1'b0;
        bus24.we    = 1'b0;
        tick();
        tick();
        chk("t5_done_old", bus24.done, 1'b1);
        chk("t5_dout_old", bus24.dout, 24'd2);
        // Write while busy is dropped
        go24();
        wr24(3'd2, 24'd9);
        tick();
        chk("t5_dout_new", bus24.dout, 24'd5);
        go24();
        tick();
        tick();
        chk("t5_dout_keep", bus24.dout, 24'd5);

        // Stall two cycles mid-run, pulse start while busy
        wr24(3'd0, 24'd2);
        wr24(3'd1, 24'd3);
        wr24(3'd2, 24'd2);
        go24();
        tick();
        bus24.en = 1'b0;
        tick();
        tick();
        chk("t6_maddr_hold", bus24.memaddr, 6'd3);
        chk("t6_busy_hold",  bus24.busy, 1'b1);
        bus24.en    = 1'b1;
        bus24.start = 1'b1;
        tick();
        bus24.start = 1'b0;
        chk("t6_no_restart", bus24.memaddr, 6'd4);
        tick();
        chk("t6_done_e3",    bus24.done, 1'b0);
        tick();
        chk("t6_done_e4",    bus24.done, 1'b1);
        chk("t6_dout",       bus24.dout, 24'd24);
        bus24.en = 1'b0;
        tick();
        chk("t6_done_frozen", bus24.done, 1'b1);
        bus24.en = 1'b1;
        tick();
        chk("t6_done_clear", bus24.done, 1'b0);

        // 16-bit instance: 4*0x7FFF*127 saturates, then wraps to 0xFE04
        wr16(3'd1, 16'd4);
        wr16(3'd2, 16'd127);
        wr16(3'd3, 16'd3);
        go16();
        for (int i = 0; i < 4; i++) tick();
        chk("t7_done_e4", bus16.done, 1'b0);
        tick();
        chk("t7_done_sat", bus16.done, 1'b1);
        chk("t7_dout_sat", bus16.dout, 16'h7FFF);
        chk("t7_ovf_sat",  bus16.ovf, 1'b1);
        wr16(3'd3, 16'd2);
        go16();
        chk("t7_ovf_clr",  bus16.ovf, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("t7_dout_wrap", bus16.dout, 16'hFE04);
        chk("t7_ovf_wrap",  bus16.ovf, 1'b1);

        // Reset mid-run aborts without done; registers return to defaults
        wr24(3'd0, 24'd2);
        wr24(3'd1, 24'd3);
        wr24(3'd2, 24'd2);
        go24();
        tick();
        rst = 1'b1;
        tick();
        chk("t8_busy",  bus24.busy, 1'b0);
        chk("t8_dout",  bus24.dout, 24'hFFFFFF);
        chk("t8_maddr", bus24.memaddr, 6'd0);
        chk("t8_done",  bus24.done, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t8_no_done", bus24.done, 1'b0);
        wr24(3'd1, 24'd1);
        go24();
        tick();
        tick();
        chk("t8_defaults_done", bus24.done, 1'b1);
        chk("t8_defaults_dout", bus24.dout, 24'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
